riscv_core_trap_sequencer: RTL and testbench
============================================

Name: riscv_core_trap_sequencer

Overview:
Machine-mode trap controller in front of the CSR file's single write port. It collects exception and interrupt requests and selects the highest priority one. It then sequences the CSR updates for trap entry and mret (mepc, mcause, mtval, mstatus) over successive cycles and issues the PC redirect. It also arbitrates the CSR write port between this sequence and ordinary Zicsr instructions from the pipeline.

Parameters:
XLEN, 64, CSR data width
PC_W, 32, program counter width

Ports:
i_riscv_core_clk  in  1  clock
i_riscv_core_rst_n  in  1  async active-low reset
i_exc_ebreak, i_exc_misaligned, i_exc_illegal, i_exc_ecall, i_exc_sw_fault, i_exc_lw_fault  in  1 each  synchronous exception requests
i_exc_pc  in  PC_W  PC of the faulting instruction
i_exc_instr  in  32  faulting instruction word
i_exc_fault_addr  in  XLEN  load/store fault address
i_mip_meip, i_mip_mtip  in  1  pending interrupts
i_mie_meie, i_mie_mtie  in  1  interrupt enables
i_mstatus  in  XLEN  current mstatus
i_mtvec  in  XLEN  current mtvec
i_mepc  in  XLEN  current mepc
i_intr_pc  in  PC_W  next-to-commit PC, saved on an interrupt
i_mret  in  1  mret request
i_csr_req_valid  in  1  pipeline CSR write request
i_csr_req_addr  in  12  pipeline CSR address
i_csr_req_wdata  in  XLEN  pipeline CSR write data
o_csr_req_ready  out  1  pipeline request accepted
o_csr_wen  out  1  CSR write strobe
o_csr_waddr  out  12  CSR write address
o_csr_wdata  out  XLEN  CSR write data
o_redirect_valid  out  1  one-cycle PC redirect
o_redirect_pc  out  PC_W  redirect target
o_flush  out  1  flush IF/ID/EXE/MEM
o_ext_ack  out  1  external interrupt acknowledge pulse
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE. Every output is 0, except o_csr_req_ready, which is 1 in IDLE. Reset asserted mid-sequence aborts it with no further writes.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, JUMP, M_STAT, M_JUMP.
- Trap pending in IDLE means either of:
  - i_mstatus[3] & ((i_mie_meie & i_mip_meip) | (i_mie_mtie & i_mip_mtip))
  - any i_exc_* asserted.
- Priority:
  - MEI (cause 1<<63 | 11) > MTI (1<<63 | 7) > ebreak (3) > misaligned (0) > illegal (2) > ecall (11) > sw_fault (7) > lw_fault (5).
  - Trap > mret > pipeline CSR request.
- Accept cycle N (IDLE): latch cause, PC, tval and instr into holding registers.
  - PC latched is i_intr_pc for an interrupt, i_exc_pc for an exception.
  - tval latched is i_exc_fault_addr for a fault, otherwise 0.
  - o_csr_req_ready = 0 in cycle N. Move to W_EPC.
- Trap entry schedule, one CSR write per cycle:
  - N+1: mepc (0x341) = zero-extended PC.
  - N+2: mcause (0x342).
  - N+3: mtval (0x343).
  - N+4: mstatus (0x300) = i_mstatus with MPIE = MIE, MIE = 0, MPP[12:11] = 2'b11.
  - N+5: JUMP, o_redirect_valid = 1, o_redirect_pc = handler. Return to IDLE at N+6.
- o_ext_ack pulses in N+1 for MEI only.
- mret accepted in IDLE (no trap pending):
  - M_STAT writes mstatus with MIE = MPIE, MPIE = 1.
  - M_JUMP redirects to i_mepc[PC_W-1:0]. Then IDLE.
- o_flush = 1 in the accept cycle and in every non-IDLE state.
- o_busy = (state != IDLE).
- Pipeline CSR request: passes through combinationally in IDLE when no trap and no mret are present (o_csr_wen = valid & ready). Otherwise ready = 0 and the request must be held.
- Exceptions and interrupts arriving while not in IDLE are ignored; the pipeline is flushed and re-presents them.
- Handler address: {i_mtvec[PC_W-1:2], 2'b00}, unless the optional feature applies.

Optional Feature:
RISCV_CORE_TRAP_VECTOR_EN
- Defined: if i_mtvec[1:0] == 2'b01 and the trap is an interrupt, handler = base + 4*cause[5:0]. Exceptions always go to base.
- Undefined: always base; mtvec[1:0] is ignored.

Decomposition:
- Package riscv_core_trap_pkg holds:
  - the state enum;
  - the cause code constants;
  - the CSR address constants 0x300/0x341/0x342/0x343;
  - the mstatus bit positions (MIE 3, MPIE 7, MPP 12:11).
- Sub-module riscv_core_trap_prio_enc: combinational priority encoder that outputs trap_valid, cause[XLEN-1:0] and is_interrupt.

Test Plan:
- i_exc_illegal, i_exc_pc = 0x100, i_mtvec = 0x8000_0000 → writes mepc = 0x100, mcause = 2, mtval = 0, mstatus.MIE = 0 in N+1..N+4; redirect to 0x8000_0000 at N+5; flush high N..N+5.
- i_exc_lw_fault and i_exc_ecall together, fault_addr = 0xDEAD → mcause = 11, mtval = 0 (ecall wins).
- MIE = 1, MEIE = 1, MEIP = 1 and i_exc_illegal together → mcause = 0x8000_0000_0000_000B, mepc = i_intr_pc, o_ext_ack pulse at N+1.
- Pipeline CSR write to 0x340 while a trap is accepted → ready = 0 until IDLE; write appears once, after the redirect.
- mret with mstatus = 0x80 and i_mepc = 0x200 → mstatus write with MIE = 1, MPIE = 1; redirect to 0x200.
- Reset asserted at W_CAUSE → all outputs 0 immediately, no mtval write; with VECTOR_EN defined, mtvec = 0x8000_0001 and MTI → redirect 0x8000_001C.

Source files
------------

// File: rtl/riscv_core_trap_pkg.sv
// Shared constants for the machine-mode trap sequencer: FSM encoding,
// trap cause codes, trap CSR addresses and mstatus bit positions.
package riscv_core_trap_pkg;

    typedef logic [2:0] trap_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_W_EPC   = 3'd1;
    localparam logic [2:0] ST_W_CAUSE = 3'd2;
    localparam logic [2:0] ST_W_TVAL  = 3'd3;
    localparam logic [2:0] ST_W_STAT  = 3'd4;
    localparam logic [2:0] ST_JUMP    = 3'd5;
    localparam logic [2:0] ST_M_STAT  = 3'd6;
    localparam logic [2:0] ST_M_JUMP  = 3'd7;

    // Low cause bits; interrupts additionally set the top bit of mcause.
    localparam logic [5:0] CAUSE_MEI         = 6'd11;
    localparam logic [5:0] CAUSE_MTI         = 6'd7;
    localparam logic [5:0] CAUSE_BREAKPOINT  = 6'd3;
    localparam logic [5:0] CAUSE_MISALIGNED  = 6'd0;
    localparam logic [5:0] CAUSE_ILLEGAL     = 6'd2;
    localparam logic [5:0] CAUSE_ECALL_M     = 6'd11;
    localparam logic [5:0] CAUSE_STORE_FAULT = 6'd7;
    localparam logic [5:0] CAUSE_LOAD_FAULT  = 6'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/riscv_core_trap_prio_enc.sv
// Combinational trap priority encoder: MEI > MTI > ebreak > misaligned >
// illegal > ecall > store fault > load fault.
module riscv_core_trap_prio_enc
    import riscv_core_trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            mstatus_mie,
    input  logic            meip,
    input  logic            mtip,
    input  logic            meie,
    input  logic            mtie,
    input  logic            exc_ebreak,
    input  logic            exc_misaligned,
    input  logic            exc_illegal,
    input  logic            exc_ecall,
    input  logic            exc_sw_fault,
    input  logic            exc_lw_fault,
    output logic            trap_valid,
    output logic [XLEN-1:0] cause,
    output logic            is_interrupt
);

    always_comb begin
        trap_valid   = 1'b1;
        is_interrupt = 1'b0;
        cause        = '0;
        if (mstatus_mie && meie && meip) begin
            is_interrupt    = 1'b1;
            cause[XLEN-1]   = 1'b1;
            cause[5:0]      = CAUSE_MEI;
        end else if (mstatus_mie && mtie && mtip) begin
            is_interrupt    = 1'b1;
            cause[XLEN-1]   = 1'b1;
            cause[5:0]      = CAUSE_MTI;
        end else if (exc_ebreak) begin
            cause[5:0] = CAUSE_BREAKPOINT;
        end else if (exc_misaligned) begin
            cause[5:0] = CAUSE_MISALIGNED;
        end else if (exc_illegal) begin
            cause[5:0] = CAUSE_ILLEGAL;
        end else if (exc_ecall) begin
            cause[5:0] = CAUSE_ECALL_M;
        end else if (exc_sw_fault) begin
            cause[5:0] = CAUSE_STORE_FAULT;
        end else if (exc_lw_fault) begin
            cause[5:0] = CAUSE_LOAD_FAULT;
        end else begin
            trap_valid = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_core_trap_sequencer.sv
// Machine-mode trap/mret sequencer owning the CSR write port.
// Define RISCV_CORE_TRAP_VECTOR_EN for vectored interrupt dispatch.
module riscv_core_trap_sequencer
    import riscv_core_trap_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 32
) (
    input  logic            i_riscv_core_clk,
    input  logic            i_riscv_core_rst_n,
    input  logic            i_exc_ebreak,
    input  logic            i_exc_misaligned,
    input  logic            i_exc_illegal,
    input  logic            i_exc_ecall,
    input  logic            i_exc_sw_fault,
    input  logic            i_exc_lw_fault,
    input  logic [PC_W-1:0] i_exc_pc,
    input  logic [31:0]     i_exc_instr,
    input  logic [XLEN-1:0] i_exc_fault_addr,
    input  logic            i_mip_meip,
    input  logic            i_mip_mtip,
    input  logic            i_mie_meie,
    input  logic            i_mie_mtie,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic [PC_W-1:0] i_intr_pc,
    input  logic            i_mret,
    input  logic            i_csr_req_valid,
    input  logic [11:0]     i_csr_req_addr,
    input  logic [XLEN-1:0] i_csr_req_wdata,
    output logic            o_csr_req_ready,
    output logic            o_csr_wen,
    output logic [11:0]     o_csr_waddr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_redirect_valid,
    output logic [PC_W-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic            o_ext_ack,
    output logic            o_busy
);

    trap_state_t     state, state_nxt;
    logic            trap_valid, trap_intr, is_fault;
    logic [XLEN-1:0] trap_cause;
    logic            idle, accept_trap;
    logic [XLEN-1:0] hold_cause, hold_tval;
    logic [PC_W-1:0] hold_pc, base, handler, vec_off;
    logic [31:0]     hold_instr;
    logic            hold_intr, hold_mei;
    logic            unused_bits;

    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    riscv_core_trap_prio_enc #(.XLEN(XLEN)) u_prio_enc (
        .mstatus_mie    (i_mstatus[MSTATUS_MIE]),
        .meip           (i_mip_meip),
        .mtip           (i_mip_mtip),
        .meie           (i_mie_meie),
        .mtie           (i_mie_mtie),
        .exc_ebreak     (i_exc_ebreak),
        .exc_misaligned (i_exc_misaligned),
        .exc_illegal    (i_exc_illegal),
        .exc_ecall      (i_exc_ecall),
        .exc_sw_fault   (i_exc_sw_fault),
        .exc_lw_fault   (i_exc_lw_fault),
        .trap_valid     (trap_valid),
        .cause          (trap_cause),
        .is_interrupt   (trap_intr)
    );

    assign idle        = (state == ST_IDLE);
    assign accept_trap = idle && trap_valid;
    assign is_fault    = !trap_intr && ((trap_cause[5:0] == CAUSE_STORE_FAULT) ||
                                        (trap_cause[5:0] == CAUSE_LOAD_FAULT));
    assign o_busy      = !idle;
    assign o_csr_req_ready = idle && !trap_valid && !i_mret;

    assign base    = {i_mtvec[PC_W-1:2], 2'b00};
    assign vec_off = {{(PC_W-8){1'b0}}, hold_cause[5:0], 2'b00};
`ifdef RISCV_CORE_TRAP_VECTOR_EN
    assign handler = (hold_intr && (i_mtvec[1:0] == 2'b01)) ? base + vec_off : base;
`else
    assign handler = base;
`endif

    assign unused_bits = ^{hold_instr, hold_intr, vec_off, i_mtvec[1:0],
                           i_mtvec[XLEN-1:PC_W], i_mepc[XLEN-1:PC_W]};

    always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
        if (!i_riscv_core_rst_n) state <= ST_IDLE;
        else                     state <= state_nxt;
    end

    // Trap context is captured only on accept and read only while sequencing.
    always_ff @(posedge i_riscv_core_clk) begin
        if (accept_trap) begin
            hold_cause <= trap_cause;
            hold_intr  <= trap_intr;
            hold_mei   <= trap_intr && (trap_cause[5:0] == CAUSE_MEI);
            hold_pc    <= trap_intr ? i_intr_pc : i_exc_pc;
            hold_tval  <= is_fault ? i_exc_fault_addr : '0;
            hold_instr <= i_exc_instr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (trap_valid) state_nxt = ST_W_EPC;
                        else if (i_mret) state_nxt = ST_M_STAT;
            ST_W_EPC:   state_nxt = ST_W_CAUSE;
            ST_W_CAUSE: state_nxt = ST_W_TVAL;
            ST_W_TVAL:  state_nxt = ST_W_STAT;
            ST_W_STAT:  state_nxt = ST_JUMP;
            ST_M_STAT:  state_nxt = ST_M_JUMP;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_csr_wen        = 1'b0;
        o_csr_waddr      = '0;
        o_csr_wdata      = '0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        o_ext_ack        = 1'b0;
        o_flush          = 1'b1;
        case (state)
            ST_IDLE: begin
                o_flush   = trap_valid || i_mret;
                o_csr_wen = i_csr_req_valid && o_csr_req_ready;
                if (o_csr_wen) begin
                    o_csr_waddr = i_csr_req_addr;
                    o_csr_wdata = i_csr_req_wdata;
                end
            end
            ST_W_EPC: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MEPC;
                o_csr_wdata = XLEN'(hold_pc);
                o_ext_ack   = hold_mei;
            end
            ST_W_CAUSE: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MCAUSE;
                o_csr_wdata = hold_cause;
            end
            ST_W_TVAL: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MTVAL;
                o_csr_wdata = hold_tval;
            end
            ST_W_STAT: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = trap_mstatus(i_mstatus);
            end
            ST_JUMP: begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = handler;
            end
            ST_M_STAT: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = mret_mstatus(i_mstatus);
            end
            default: begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = i_mepc[PC_W-1:0];
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_core_trap_sequencer.sv
// Self-checking bench for riscv_core_trap_sequencer: directed scenarios plus
// randomized traffic against a schedule-based reference model.
module tb_riscv_core_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_ebreak, exc_misaligned, exc_illegal, exc_ecall, exc_sw_fault, exc_lw_fault;
    logic [31:0] exc_pc, exc_instr, intr_pc;
    logic [63:0] exc_fault_addr, mstatus, mtvec, mepc;
    logic        mip_meip, mip_mtip, mie_meie, mie_mtie, mret;
    logic        req_valid;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_ready, csr_wen, redirect_valid, flush, ext_ack, busy;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;
    int n340     = 0;
    logic [63:0] seen [0:4095];
    logic [31:0] last_redir;
    bit          req_taken = 0;

    // reference model: queue of pending sequence steps plus captured trap context
    int          q[$];
    logic [63:0] m_cause, m_tval;
    logic [31:0] m_pc;
    bit          m_intr, m_mei;

    always #5 clk = ~clk;

    riscv_core_trap_sequencer #(.XLEN(64), .PC_W(32)) dut (
        .i_riscv_core_clk   (clk),
        .i_riscv_core_rst_n (rst_n),
        .i_exc_ebreak       (exc_ebreak),
        .i_exc_misaligned   (exc_misaligned),
        .i_exc_illegal      (exc_illegal),
        .i_exc_ecall        (exc_ecall),
        .i_exc_sw_fault     (exc_sw_fault),
        .i_exc_lw_fault     (exc_lw_fault),
        .i_exc_pc           (exc_pc),
        .i_exc_instr        (exc_instr),
        .i_exc_fault_addr   (exc_fault_addr),
        .i_mip_meip         (mip_meip),
        .i_mip_mtip         (mip_mtip),
        .i_mie_meie         (mie_meie),
        .i_mie_mtie         (mie_mtie),
        .i_mstatus          (mstatus),
        .i_mtvec            (mtvec),
        .i_mepc             (mepc),
        .i_intr_pc          (intr_pc),
        .i_mret             (mret),
        .i_csr_req_valid    (req_valid),
        .i_csr_req_addr     (req_addr),
        .i_csr_req_wdata    (req_wdata),
        .o_csr_req_ready    (req_ready),
        .o_csr_wen          (csr_wen),
        .o_csr_waddr        (csr_waddr),
        .o_csr_wdata        (csr_wdata),
        .o_redirect_valid   (redirect_valid),
        .o_redirect_pc      (redirect_pc),
        .o_flush            (flush),
        .o_ext_ack          (ext_ack),
        .o_busy             (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_trig();
        {exc_ebreak, exc_misaligned, exc_illegal, exc_ecall, exc_sw_fault, exc_lw_fault} = '0;
        {mip_meip, mip_mtip, mie_meie, mie_mtie, mret} = '0;
    endtask

    task automatic sync();
        @(negedge clk);
        if (req_taken) begin
            req_valid = 1'b0;
            req_taken = 0;
        end
    endtask

    function automatic logic [63:0] ms_after_trap(input logic [63:0] ms);
        return (ms & ~64'h1888) | (64'(ms[3]) << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] ms_after_mret(input logic [63:0] ms);
        return (ms & ~64'h88) | (64'(ms[7]) << 3) | 64'h80;
    endfunction

    function automatic logic [31:0] handler_addr();
        logic [31:0] b;
        b = mtvec[31:0] & 32'hFFFF_FFFC;
`ifdef RISCV_CORE_TRAP_VECTOR_EN
        if (mtvec[1:0] == 2'b01 && m_intr) b = b + 32'(4 * (m_cause & 64'd63));
`endif
        return b;
    endfunction

    // Compares all outputs in the current cycle, then advances the model.
    task automatic check_cycle();
        logic        e_wen, e_rv, e_flush, e_ack, e_busy, e_ready;
        logic [11:0] e_addr;
        logic [63:0] e_data;
        logic [31:0] e_rpc;
        bit          ex[6];
        int          codes[6] = '{3, 0, 2, 11, 7, 5};
        int          step, hit;
        #1;
        {e_wen, e_rv, e_flush, e_ack, e_busy, e_ready} = '0;
        e_addr = '0; e_data = '0; e_rpc = '0;
        if (q.size() > 0) begin
            step = q.pop_front();
            e_busy = 1; e_flush = 1;
            case (step)
                0: begin e_wen = 1; e_addr = 12'h341; e_data = {32'h0, m_pc}; e_ack = m_mei; end
                1: begin e_wen = 1; e_addr = 12'h342; e_data = m_cause; end
                2: begin e_wen = 1; e_addr = 12'h343; e_data = m_tval; end
                3: begin e_wen = 1; e_addr = 12'h300; e_data = ms_after_trap(mstatus); end
                4: begin e_rv = 1; e_rpc = handler_addr(); end
                5: begin e_wen = 1; e_addr = 12'h300; e_data = ms_after_mret(mstatus); end
                default: begin e_rv = 1; e_rpc = mepc[31:0]; end
            endcase
        end else begin
            ex = '{exc_ebreak, exc_misaligned, exc_illegal, exc_ecall, exc_sw_fault, exc_lw_fault};
            hit = -1;
            for (int i = 5; i >= 0; i--) if (ex[i]) hit = i;
            if (mstatus[3] && mie_meie && mip_meip) begin
                m_intr = 1; m_mei = 1; m_cause = 64'h8000_0000_0000_000B;
            end else if (mstatus[3] && mie_mtie && mip_mtip) begin
                m_intr = 1; m_mei = 0; m_cause = 64'h8000_0000_0000_0007;
            end else if (hit >= 0) begin
                m_intr = 0; m_mei = 0; m_cause = 64'(codes[hit]);
            end
            if (m_intr && (m_cause[63] == 1'b1) && ((mstatus[3] && mie_meie && mip_meip) ||
                                                  (mstatus[3] && mie_mtie && mip_mtip)) || hit >= 0) begin
                if (!(mstatus[3] && ((mie_meie && mip_meip) || (mie_mtie && mip_mtip)))) m_intr = 0;
                e_flush = 1;
                m_pc   = m_intr ? intr_pc : exc_pc;
                m_tval = (!m_intr && (m_cause == 7 || m_cause == 5)) ? exc_fault_addr : 64'h0;
                q = '{0, 1, 2, 3, 4};
            end else if (mret) begin
                e_flush = 1;
                q = '{5, 6};
            end else begin
                e_ready = 1;
                if (req_valid) begin
                    e_wen = 1; e_addr = req_addr; e_data = req_wdata;
                    req_taken = 1;
                end
            end
        end
        check_eq("csr_wen", 64'(csr_wen), 64'(e_wen));
        check_eq("csr_waddr", 64'(csr_waddr), 64'(e_addr));
        check_eq("csr_wdata", csr_wdata, e_data);
        check_eq("redirect_valid", 64'(redirect_valid), 64'(e_rv));
        check_eq("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
        check_eq("flush", 64'(flush), 64'(e_flush));
        check_eq("ext_ack", 64'(ext_ack), 64'(e_ack));
        check_eq("busy", 64'(busy), 64'(e_busy));
        check_eq("req_ready", 64'(req_ready), 64'(e_ready));
        if (csr_wen) seen[csr_waddr] = csr_wdata;
        if (csr_wen && csr_waddr == 12'h340) n340++;
        if (redirect_valid) last_redir = redirect_pc;
    endtask

    task automatic noise();
        {exc_ebreak, exc_misaligned, exc_illegal, exc_ecall, exc_sw_fault, exc_lw_fault} = 6'($urandom);
        {mip_meip, mip_mtip, mie_meie, mie_mtie, mret} = 5'($urandom);
        mstatus = {$urandom, $urandom};
        mtvec   = {$urandom, $urandom};
        mepc    = {$urandom, $urandom};
        exc_pc  = $urandom; intr_pc = $urandom; exc_instr = $urandom;
        exc_fault_addr = {$urandom, $urandom};
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            sync();
            clear_trig();
            check_cycle();
        end
        check_eq("drain_done", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_trig();
        exc_pc = '0; exc_instr = '0; intr_pc = '0; exc_fault_addr = '0;
        mstatus = '0; mtvec = '0; mepc = '0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        last_redir = '0;
        for (int i = 0; i < 4096; i++) seen[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_wen", 64'(csr_wen), 64'd0);
        check_eq("rst_redirect", 64'(redirect_valid), 64'd0);
        check_eq("rst_flush", 64'(flush), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // illegal instruction at 0x100, direct mtvec
        sync(); clear_trig();
        exc_illegal = 1; exc_pc = 32'h100; mtvec = 64'h8000_0000; mstatus = 64'h8;
        check_cycle(); drain();
        check_eq("t1_mepc", seen[12'h341], 64'h100);
        check_eq("t1_mcause", seen[12'h342], 64'd2);
        check_eq("t1_mtval", seen[12'h343], 64'd0);
        check_eq("t1_mstatus_mie", 64'(seen[12'h300][3]), 64'd0);
        check_eq("t1_redirect", 64'(last_redir), 64'h8000_0000);

        // ecall outranks load fault; tval stays 0
        sync(); clear_trig();
        exc_lw_fault = 1; exc_ecall = 1; exc_fault_addr = 64'hDEAD; exc_pc = 32'h204;
        check_cycle(); drain();
        check_eq("t2_mcause", seen[12'h342], 64'd11);
        check_eq("t2_mtval", seen[12'h343], 64'd0);

        // external interrupt beats a concurrent exception
        sync(); clear_trig();
        mstatus = 64'h8; mie_meie = 1; mip_meip = 1; exc_illegal = 1; intr_pc = 32'h444; exc_pc = 32'h888;
        check_cycle(); drain();
        check_eq("t3_mcause", seen[12'h342], 64'h8000_0000_0000_000B);
        check_eq("t3_mepc", seen[12'h341], 64'h444);

        // pipeline CSR write held off by a trap, lands once afterwards
        n340 = 0;
        sync(); clear_trig();
        exc_illegal = 1; req_valid = 1; req_addr = 12'h340; req_wdata = 64'h55;
        check_cycle(); drain();
        sync(); check_cycle();
        sync(); check_cycle();
        check_eq("t4_writes_340", 64'(n340), 64'd1);
        check_eq("t4_data_340", seen[12'h340], 64'h55);

        // mret
        sync(); clear_trig();
        mret = 1; mstatus = 64'h80; mepc = 64'h200;
        check_cycle(); drain();
        check_eq("t5_mstatus", seen[12'h300], 64'h88);
        check_eq("t5_redirect", 64'(last_redir), 64'h200);

        // timer interrupt with mtvec mode bits 01
        sync(); clear_trig();
        mstatus = 64'h8; mie_mtie = 1; mip_mtip = 1; mtvec = 64'h8000_0001;
        check_cycle(); drain();
`ifdef RISCV_CORE_TRAP_VECTOR_EN
        check_eq("t6_vector", 64'(last_redir), 64'h8000_001C);
`else
        check_eq("t6_vector", 64'(last_redir), 64'h8000_0000);
`endif

        // reset while writing mcause
        seen[12'h343] = 64'hA5A5;
        sync(); clear_trig();
        exc_sw_fault = 1; exc_fault_addr = 64'hBEEF;
        check_cycle();
        sync(); clear_trig(); check_cycle();
        sync();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_wen", 64'(csr_wen), 64'd0);
        check_eq("rst_mid_flush", 64'(flush), 64'd0);
        check_eq("rst_mid_redirect", 64'(redirect_valid), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sync(); check_cycle();
        end
        check_eq("rst_mid_no_mtval", seen[12'h343], 64'hA5A5);

        // randomized traffic
        for (int t = 0; t < 1500; t++) begin
            sync();
            if (q.size() > 0) begin
                noise();
            end else begin
                clear_trig();
                exc_ebreak     = ($urandom_range(0, 15) == 0);
                exc_misaligned = ($urandom_range(0, 15) == 0);
                exc_illegal    = ($urandom_range(0, 15) == 0);
                exc_ecall      = ($urandom_range(0, 15) == 0);
                exc_sw_fault   = ($urandom_range(0, 15) == 0);
                exc_lw_fault   = ($urandom_range(0, 15) == 0);
                {mie_meie, mie_mtie} = 2'($urandom);
                mip_meip = ($urandom_range(0, 5) == 0);
                mip_mtip = ($urandom_range(0, 5) == 0);
                mret     = ($urandom_range(0, 5) == 0);
                mstatus  = {$urandom, $urandom};
                mtvec    = {$urandom, $urandom};
                mepc     = {$urandom, $urandom};
                exc_pc   = $urandom; intr_pc = $urandom; exc_instr = $urandom;
                exc_fault_addr = {$urandom, $urandom};
                if (!req_valid && $urandom_range(0, 2) == 0) begin
                    req_valid = 1; req_addr = 12'($urandom); req_wdata = {$urandom, $urandom};
                end
            end
            check_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
